// File: rtl/bsh_32_norm_pkg.sv
// Shared constants and stage payload types for the 32-bit normalizer.
package bsh_32_norm_pkg;

  localparam int unsigned BSH_DW  = 32;
  localparam int unsigned BSH_SHW = 5;

  localparam logic BSH_DIR_LEFT  = 1'b0;
  localparam logic BSH_DIR_RIGHT = 1'b1;

  // cnt_word is the word the leading-zero counter sees (bit-reversed for dir=1).
  typedef struct packed {
    logic [BSH_DW-1:0] word;
    logic [BSH_DW-1:0] cnt_word;
    logic              dir;
  } s1_t;

  typedef struct packed {
    logic [BSH_DW-1:0]  word;
    logic [BSH_SHW-1:0] sh;
    logic               zero;
    logic               dir;
  } s2_t;

  typedef struct packed {
    logic [BSH_DW-1:0]  data;
    logic [BSH_SHW-1:0] sh;
    logic               dir;
    logic               zero;
  } res_t;

endpackage

// File: rtl/bsh_32_norm_bsh.sv
// Logarithmic 32-bit logical barrel shifter, zero fill, no wrap.
// left=1 shifts toward the MSB, left=0 toward the LSB.
module bsh_32 (
  input  logic [31:0] data_in,
  input  logic [4:0]  sh,
  input  logic        left,
  output logic [31:0] data_out
);

  logic [31:0] stage [6];

  assign stage[0] = data_in;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      assign stage[gi+1] = !sh[gi] ? stage[gi]
                         : left    ? (stage[gi] << (1 << gi))
                         :           (stage[gi] >> (1 << gi));
    end
  endgenerate

  assign data_out = stage[5];

endmodule

// File: rtl/bsh_32_norm_lzc.sv
// Combinational 32-bit leading-zero counter built as a binary tree of
// 2-bit leaves; each merge prefers the upper half unless it is all zero.
module lzc_32 (
  input  logic [31:0] word,
  output logic [4:0]  count,
  output logic        all_zero
);

  logic [15:0] z0;
  logic [15:0] c0;
  logic [7:0]  z1;
  logic [1:0]  c1 [8];
  logic [3:0]  z2;
  logic [2:0]  c2 [4];
  logic [1:0]  z3;
  logic [3:0]  c3 [2];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_leaf
      assign z0[gi] = ~(word[2*gi+1] | word[2*gi]);
      assign c0[gi] = ~word[2*gi+1];
    end

    for (gi = 0; gi < 8; gi++) begin : g_lvl1
      assign z1[gi] = z0[2*gi+1] & z0[2*gi];
      assign c1[gi] = z0[2*gi+1] ? {1'b1, c0[2*gi]} : {1'b0, c0[2*gi+1]};
    end

    for (gi = 0; gi < 4; gi++) begin : g_lvl2
      assign z2[gi] = z1[2*gi+1] & z1[2*gi];
      assign c2[gi] = z1[2*gi+1] ? {1'b1, c1[2*gi]} : {1'b0, c1[2*gi+1]};
    end

    for (gi = 0; gi < 2; gi++) begin : g_lvl3
      assign z3[gi] = z2[2*gi+1] & z2[2*gi];
      assign c3[gi] = z2[2*gi+1] ? {1'b1, c2[2*gi]} : {1'b0, c2[2*gi+1]};
    end
  endgenerate

  assign all_zero = z3[1] & z3[0];
  assign count    = z3[1] ? {1'b1, c3[0]} : {1'b0, c3[1]};

endmodule

// File: rtl/bsh_32_norm.sv
// Three-stage elastic normalizer: S1 capture, S2 leading-zero count, S3 shift.
// Each stage loads when empty or when its contents move on the same edge.
module bsh_32_norm
  import bsh_32_norm_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BSH_DW-1:0]  data_in,
  input  logic               dir,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BSH_DW-1:0]  data_out,
  output logic [BSH_SHW-1:0] sh_out,
  output logic               dir_out,
  output logic               zero
);

  logic s1_valid_reg;
  logic s2_valid_reg;
  logic out_valid_reg;
  s1_t  s1_reg;
  s2_t  s2_reg;
  res_t res_reg;

  s1_t  s1_next;
  s2_t  s2_next;
  res_t res_next;

  logic s3_ready;
  logic s2_ready;
  logic s1_ready;
  logic accept;

  logic [BSH_DW-1:0]  data_rev;
  logic [BSH_DW-1:0]  shifted;
  logic [BSH_SHW-1:0] lzc_count;
  logic               lzc_zero;

  genvar gi;
  generate
    for (gi = 0; gi < BSH_DW; gi++) begin : g_rev
      assign data_rev[gi] = data_in[BSH_DW-1-gi];
    end
  endgenerate

  // Ready ripples back combinationally from out_ready so a full pipe refills in one edge.
  assign s3_ready = !out_valid_reg || out_ready;
  assign s2_ready = !s2_valid_reg  || s3_ready;
  assign s1_ready = !s1_valid_reg  || s2_ready;
  assign in_ready = rstn && s1_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_next          = '0;
    s1_next.word     = data_in;
    s1_next.dir      = dir;
    s1_next.cnt_word = (dir == BSH_DIR_RIGHT) ? data_rev : data_in;
  end

  lzc_32 u_lzc (
    .word     (s1_reg.cnt_word),
    .count    (lzc_count),
    .all_zero (lzc_zero)
  );

  always_comb begin
    s2_next      = '0;
    s2_next.word = s1_reg.word;
    s2_next.sh   = lzc_zero ? '0 : lzc_count;
    s2_next.zero = lzc_zero;
    s2_next.dir  = s1_reg.dir;
  end

  bsh_32 u_shift (
    .data_in  (s2_reg.word),
    .sh       (s2_reg.sh),
    .left     (s2_reg.dir == BSH_DIR_LEFT),
    .data_out (shifted)
  );

  always_comb begin
    res_next      = '0;
    res_next.data = shifted;
    res_next.sh   = s2_reg.sh;
    res_next.dir  = s2_reg.dir;
    res_next.zero = s2_reg.zero;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      s1_reg        <= '0;
      s2_reg        <= '0;
      res_reg       <= '0;
    end else begin
      if (s1_ready) s1_valid_reg <= in_valid;
      if (accept)   s1_reg       <= s1_next;

      if (s2_ready)                 s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg && s2_ready) s2_reg       <= s2_next;

      if (s3_ready)                 out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg && s3_ready) res_reg       <= res_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign data_out  = res_reg.data;
  assign sh_out    = res_reg.sh;
  assign dir_out   = res_reg.dir;
  assign zero      = res_reg.zero;

endmodule
